pipelined_memory: RTL and testbench

PIPELINED_MEMORY -- requirements
Module: pipelined_memory

---
 rtl/pipelined_memory.sv | 154 +++++++++++++++
 tb/tb_pipelined_memory.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_memory.sv
// Word memory with byte-enabled writes and a latency-fixed, credit-flow-controlled read path.
// Reads flow through an RD_LAT-stage pipeline into a MAX_OUT-entry in-order response FIFO.
module pipelined_memory #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DEPTH     = 1000,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned MAX_OUT   = 4,
    parameter int unsigned INIT_MODE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned AW1   = ADDR_W + 1;

    // Power-up content of word i.
    function automatic logic [DATA_W-1:0] init_word(input logic [IDX_W-1:0] i);
        if (INIT_MODE == 1) return DATA_W'(i);
        return '0;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Array holds each word XOR its power-up pattern, so an all-zero array reads back
    // as the INIT_MODE contents; rst never touches it.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_e;
    logic [DATA_W-1:0] pipe_d [RD_LAT];

    logic [DATA_W-1:0] fifo_d [MAX_OUT];
    logic [MAX_OUT-1:0] fifo_e;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic [CNT_W-1:0]  fcnt, fcnt_nx, credit, credit_nx;

    logic              in_range, rd_acc, wr_en, push, pop;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] init_w, rd_data, head_d;
    logic              head_e;

    // Request decode, credit/FIFO next state and next registered head.
    always_comb begin
        in_range  = AW1'(req_addr) < AW1'(DEPTH);
        idx       = IDX_W'(req_addr);
        init_w    = init_word(idx);
        rd_data   = in_range ? (mem[idx] ^ init_w) : '0;
        rd_acc    = req_valid & req_ready & ~req_we;
        wr_en     = req_valid & req_ready & req_we & in_range;
        push      = pipe_v[RD_LAT-1];
        pop       = rsp_valid & rsp_ready;

        credit_nx = credit;
        if (rd_acc && !pop)      credit_nx = credit + 1'b1;
        else if (!rd_acc && pop) credit_nx = credit - 1'b1;

        fcnt_nx = fcnt;
        if (push && !pop)      fcnt_nx = fcnt + 1'b1;
        else if (!push && pop) fcnt_nx = fcnt - 1'b1;

        wr_ptr_nx = push ? ptr_inc(wr_ptr) : wr_ptr;
        rd_ptr_nx = pop  ? ptr_inc(rd_ptr) : rd_ptr;

        head_d = pipe_d[RD_LAT-1];
        head_e = pipe_e[RD_LAT-1];
        if (pop) begin
            if (fcnt > CNT_W'(1)) begin
                head_d = fifo_d[ptr_inc(rd_ptr)];
                head_e = fifo_e[ptr_inc(rd_ptr)];
            end
        end else if (fcnt != '0) begin
            head_d = fifo_d[rd_ptr];
            head_e = fifo_e[rd_ptr];
        end
        if (fcnt_nx == '0) begin
            head_d = '0;
            head_e = 1'b0;
        end
    end

    // Byte-enabled memory write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (req_be[b]) mem[idx][b*8 +: 8] <= req_wdata[b*8 +: 8] ^ init_w[b*8 +: 8];
            end
        end
    end

    // Read pipeline valid chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= rd_acc;
            for (int k = 1; k < RD_LAT; k++) pipe_v[k] <= pipe_v[k-1];
        end
    end

    // Read pipeline payload and FIFO storage.
    always_ff @(posedge clk) begin
        pipe_d[0] <= rd_data;
        pipe_e[0] <= ~in_range;
        for (int k = 1; k < RD_LAT; k++) begin
            pipe_d[k] <= pipe_d[k-1];
            pipe_e[k] <= pipe_e[k-1];
        end
        if (push) begin
            fifo_d[wr_ptr] <= pipe_d[RD_LAT-1];
            fifo_e[wr_ptr] <= pipe_e[RD_LAT-1];
        end
    end

    // Credit counter, FIFO pointers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit    <= '0;
            fcnt      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            credit    <= credit_nx;
            fcnt      <= fcnt_nx;
            wr_ptr    <= wr_ptr_nx;
            rd_ptr    <= rd_ptr_nx;
            req_ready <= credit_nx < CNT_W'(MAX_OUT);
            rsp_valid <= fcnt_nx != '0;
            rsp_rdata <= head_d;
            rsp_err   <= head_e;
        end
    end

endmodule

// File: tb/tb_pipelined_memory.sv
// Scoreboard bench for pipelined_memory: an array model predicts read data, a queue holds
// expected responses, and a negedge monitor checks every popped response.
module tb_pipelined_memory;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int DEPTH   = 1000;
    localparam int RD_LAT  = 2;
    localparam int MAX_OUT = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_we = 1'b0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic [DATA_W-1:0]   req_wdata = '0;
    logic [DATA_W/8-1:0] req_be = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;

    pipelined_memory #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .RD_LAT(RD_LAT), .MAX_OUT(MAX_OUT), .INIT_MODE(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int acc_rd = 0;
    int pops   = 0;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W:0]   exp_q [$];
    logic [DATA_W:0]   exp_e;
    logic [DATA_W:0]   prev_rsp;
    logic              prev_hold = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One request cycle: check flow control against the model, drive, update the model.
    task automatic step(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [1:0] be, input logic rr,
                        output logic acc);
        chk("req_ready", 32'(req_ready), 32'((acc_rd - pops) < MAX_OUT));
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be; rsp_ready = rr;
        acc = v && req_ready;
        if (acc) begin
            if (we) begin
                if (a < DEPTH) begin
                    if (be[0]) ref_mem[a][7:0]  = d[7:0];
                    if (be[1]) ref_mem[a][15:8] = d[15:8];
                end
            end else begin
                acc_rd++;
                exp_q.push_back((a < DEPTH) ? {1'b0, ref_mem[a]} : {1'b1, 16'h0000});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic rr, input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 2'b00, rr, acc);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic rr);
        logic acc;
        step(1'b1, 1'b0, a, '0, 2'b00, rr, acc);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [1:0] be);
        logic acc;
        step(1'b1, 1'b1, a, d, be, 1'b1, acc);
    endtask

    // Response monitor: hold-stability and in-order scoreboard compare.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_hold) begin
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_data", 32'({rsp_err, rsp_rdata}), 32'(prev_rsp));
            end
            if (rsp_valid && rsp_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got %h expected none at %0t", {rsp_err, rsp_rdata}, $time);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("rsp", 32'({rsp_err, rsp_rdata}), 32'(exp_e));
                end
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_rsp  = {rsp_err, rsp_rdata};
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        logic acc;
        int   n;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'(i);

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;

        // Power-up content and exact read latency.
        rd(16'd25, 1'b1);
        for (int k = 1; k <= RD_LAT; k++) begin
            idle(1'b1, 1);
            chk("latency_valid", 32'(rsp_valid), 32'(k == RD_LAT));
        end
        idle(1'b1, 2);

        // Byte-enabled write followed immediately by a read.
        wr(16'd12, 16'hABCD, 2'b01);
        rd(16'd12, 1'b1);
        idle(1'b1, 4);

        // Out-of-range writes are dropped, including one that aliases word 12.
        wr(16'd1000, 16'hBEEF, 2'b11);
        wr(16'd1036, 16'h5555, 2'b11);
        rd(16'd1000, 1'b1);
        rd(16'd12, 1'b1);
        rd(16'hFFFF, 1'b1);
        idle(1'b1, 4);

        // Credit exhaustion with the consumer stalled.
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 16'(100 + i), '0, 2'b00, 1'b0, acc);
            if (acc) n++;
        end
        chk("fill_accepts", 32'(n), 32'(MAX_OUT));
        chk("full_ready", 32'(req_ready), 32'd0);
        idle(1'b1, 1);
        chk("ready_after_pop", 32'(req_ready), 32'd1);
        idle(1'b1, 6);

        // Read accept and pop in the same cycle at MAX_OUT-1 credits in use.
        for (int i = 0; i < MAX_OUT - 1; i++) rd(16'(200 + i), 1'b0);
        idle(1'b0, RD_LAT + 1);
        rd(16'd203, 1'b1);
        chk("accept_pop_ready", 32'(req_ready), 32'd1);
        idle(1'b1, 8);

        // Reset with responses buffered.
        wr(16'd300, 16'h1234, 2'b11);
        for (int i = 0; i < 3; i++) rd(16'(400 + i), 1'b0);
        idle(1'b0, RD_LAT + 2);
        chk("buffered_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        exp_q.delete();
        acc_rd = 0;
        pops = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1'b1, 6);
        rd(16'd300, 1'b1);
        rd(16'd12, 1'b1);
        idle(1'b1, 4);

        // Randomized traffic with a randomly stalling consumer.
        for (int i = 0; i < 400; i++) begin
            logic [ADDR_W-1:0] a;
            case ($urandom_range(0, 9))
                0:       a = 16'($urandom_range(1000, 65535));
                1, 2, 3: a = 16'($urandom_range(0, 1023));
                default: a = 16'($urandom_range(0, 40));
            endcase
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), a,
                 16'($urandom), 2'($urandom), ($urandom_range(0, 2) != 0), acc);
        end

        // Drain with a bounded wait.
        req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            idle(1'b1, 1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d responses outstanding expected 0", exp_q.size());
        end
        idle(1'b1, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
